// File: rtl/vx_gpu_pkg.sv
// rtl/vx_gpu_pkg.sv - shared types for the RAM-backed FIFO: output skid-buffer states.
package vx_gpu_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  // Entries currently held in the output skid buffer.
  function automatic logic [1:0] skid_level(skid_state_t s);
    return (s == TWO) ? 2'd2 : (s == ONE) ? 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/vx_dp_ram.sv
// rtl/vx_dp_ram.sv - dual-port RAM, one write port with lane enables, one read port (optionally registered).
module vx_dp_ram #(
  parameter int DATAW      = 32,
  parameter int SIZE       = 16,
  parameter int WRENW      = 1,
  parameter int OUT_REG    = 0,
  parameter int NO_RWCHECK = 0,
  parameter int ADDRW      = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             write,
  input  logic [WRENW-1:0] wren,
  input  logic [ADDRW-1:0] waddr,
  input  logic [DATAW-1:0] wdata,
  input  logic             read,
  input  logic [ADDRW-1:0] raddr,
  output logic [DATAW-1:0] rdata
);

  localparam int LANEW = DATAW / WRENW;

  logic [DATAW-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (write) begin
      for (int i = 0; i < WRENW; i++) begin
        if (wren[i]) mem[waddr][i*LANEW +: LANEW] <= wdata[i*LANEW +: LANEW];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATAW-1:0] rdata_r;
      // Without NO_RWCHECK a colliding read returns the new write data.
      always_ff @(posedge clk) begin
        if (read) begin
          if (NO_RWCHECK == 0 && write && waddr == raddr) rdata_r <= wdata;
          else                                            rdata_r <= mem[raddr];
        end
      end
      assign rdata = rdata_r;
    end else begin : g_out_comb
      assign rdata = mem[raddr];
    end
  endgenerate

endmodule

// File: rtl/vx_ram_fifo.sv
// rtl/vx_ram_fifo.sv - RAM-backed FIFO with registered push_ready and 2-entry output skid buffer.
// Optional RAM_FIFO_PERF_EN adds a full-stall cycle counter output.
module vx_ram_fifo
  import vx_gpu_pkg::*;
#(
  parameter int DATAW = 32,
  parameter int DEPTH = 16,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  input  logic [DATAW-1:0] push_data,
  output logic             push_ready,
  output logic             pop_valid,
  output logic [DATAW-1:0] pop_data,
  input  logic             pop_ready,
  output logic [CNTW-1:0]  count
`ifdef RAM_FIFO_PERF_EN
  ,
  output logic [31:0]      perf_full_stalls
`endif
);

  localparam int ADDRW = $clog2(DEPTH);

  generate
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("vx_ram_fifo: DEPTH must be a power of 2 and at least 4");
    end
  endgenerate

  logic             push_fire;
  logic             pop_fire;
  logic             rd_fire;
  logic             rd_pending;
  logic [ADDRW-1:0] wr_ptr;
  logic [ADDRW-1:0] rd_ptr;
  logic [CNTW-1:0]  ram_cnt;
  logic [CNTW-1:0]  count_next;
  logic [2:0]       level_next;
  logic [DATAW-1:0] rd_data;
  logic [DATAW-1:0] buf0;
  logic [DATAW-1:0] buf1;
  skid_state_t      state;
  skid_state_t      state_next;

  assign push_fire  = push_valid & push_ready;
  assign pop_fire   = pop_valid & pop_ready;
  assign count_next = count + CNTW'(push_fire) - CNTW'(pop_fire);

  // Skid occupancy after this edge's pop, counting the read already in flight.
  assign level_next = 3'(skid_level(state)) + 3'(rd_pending) - 3'(pop_fire);
  assign rd_fire    = (ram_cnt != '0) && (level_next < 3'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_cnt    <= '0;
      rd_pending <= 1'b0;
      count      <= '0;
      push_ready <= 1'b1;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + ADDRW'(1);
      if (rd_fire)   rd_ptr <= rd_ptr + ADDRW'(1);
      ram_cnt    <= ram_cnt + CNTW'(push_fire) - CNTW'(rd_fire);
      rd_pending <= rd_fire;
      count      <= count_next;
      push_ready <= (count_next < CNTW'(DEPTH));
    end
  end

  vx_dp_ram #(
    .DATAW      (DATAW),
    .SIZE       (DEPTH),
    .WRENW      (1),
    .OUT_REG    (1),
    .NO_RWCHECK (1)
  ) ram (
    .clk   (clk),
    .write (push_fire),
    .wren  (1'b1),
    .waddr (wr_ptr),
    .wdata (push_data),
    .read  (rd_fire),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (rd_pending) state_next = ONE;
      ONE: begin
        if (rd_pending && !pop_fire)      state_next = TWO;
        else if (!rd_pending && pop_fire) state_next = EMPTY;
      end
      TWO:     if (pop_fire) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    pop_valid = (state != EMPTY);
    pop_data  = buf0;
  end

  // Buffered data carries no reset; it is don't-care while pop_valid is low.
  always_ff @(posedge clk) begin
    if (pop_fire) begin
      if (state == TWO)    buf0 <= buf1;
      else if (rd_pending) buf0 <= rd_data;
    end else if (rd_pending) begin
      if (state == EMPTY) buf0 <= rd_data;
      else                buf1 <= rd_data;
    end
  end

  always @(posedge clk) begin
    if (!reset) assert (!(state == TWO && rd_pending)) else $error("vx_ram_fifo: arrival into full skid buffer");
  end

`ifdef RAM_FIFO_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         perf_full_stalls <= '0;
    else if (push_valid && !push_ready) perf_full_stalls <= perf_full_stalls + 32'd1;
  end
`endif

endmodule
